debounced_edge_detector: RTL and testbench
==========================================

# debounced_edge_detector

Multi-channel, parametrised edge detector for asynchronous push-button and switch inputs that feed the sequential multiplier control path. Each channel synchronises its raw input, debounces it with a stable-count filter, and emits one-cycle event pulses on rising edges, falling edges or both, selected at run time. It replaces single-channel, single-mode rising-edge detection at the board-input boundary.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flop depth per channel (≥2).
- DEBOUNCE_CYCLES, 16: consecutive equal synchronised samples required to accept a new level (≥1).
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- w  input  CHANNELS  raw asynchronous inputs, one bit per channel.
- edge_mode  input  2  00 rising, 01 falling, 10 both, 11 events disabled; sampled every cycle, common to all channels.
- event_clr  input  CHANNELS  per-channel clear for sticky flags.
- level  output  CHANNELS  debounced level per channel.
- z  output  CHANNELS  one-cycle event pulse per channel.
- any_z  output  1  OR of z, registered with z.
- event_flag  output  CHANNELS  sticky event flags.

## Operation
- Reset values: sync chain 0, all channel FSMs LOW, counters 0, level 0, z 0, any_z 0, event_flag 0.
- Synchroniser: w[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Per-channel FSM states LOW, RISE_WAIT, HIGH, FALL_WAIT; counter width clog2(DEBOUNCE_CYCLES+1).
- LOW: s=1 → RISE_WAIT, cnt=1. If DEBOUNCE_CYCLES=1, go directly to HIGH and fire the rise event.
- RISE_WAIT: s=0 → LOW, cnt=0. s=1 and cnt=DEBOUNCE_CYCLES-1 → HIGH, cnt=0, rise event. Otherwise cnt+1.
- HIGH and FALL_WAIT mirror these states with s inverted; accepting the level fires the fall event.
- level[i]=1 in HIGH and FALL_WAIT, 0 in LOW and RISE_WAIT. Wait states do not change level.
- z[i]=1 for exactly one cycle when an accepted event matches edge_mode. The mode is sampled on the same edge that accepts the level. Mode 11 suppresses z but the FSM still tracks.
- A bounce during a wait state restarts filtering. No partial credit is kept.
- An input high at reset release debounces and produces a rising event, because the FSM starts in LOW.
- Reset mid-wait: counter and state are discarded immediately. No pulse is produced.

## Timing
- w[i] first captured at edge 0 and held: s[i] is valid after edge SYNC_STAGES-1. The level is accepted at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. z[i] and level[i] are high in the following cycle.
- Default latency: 17 edges from first capture to pulse.
- z is registered (no combinational path from w or edge_mode). any_z is aligned with z.
- Minimum spacing between two same-direction events is 2·DEBOUNCE_CYCLES cycles.

## Configuration
- EDGE_STICKY_EN defined: event_flag[i] sets on every z[i] pulse and clears on event_clr[i]. If set and clear occur in the same cycle, set wins. The flag clears cycle-accurately one edge after event_clr.
- EDGE_STICKY_EN undefined: event_flag is tied to 0, event_clr is ignored and no flag flops are synthesised. Ports remain present.

## Structure
- Package edge_det_pkg holds:
  - the state enum (LOW, RISE_WAIT, HIGH, FALL_WAIT);
  - edge_mode constants (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF);
  - the counter-width function.
- Sub-module edge_channel: synchroniser, FSM, counter, level and the z/flag flops for one channel.
- Top instantiates CHANNELS copies of edge_channel via generate and registers any_z.

## Test plan
- CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, mode 00; hold w[0] high from edge 0 → z[0] high for exactly one cycle after edge 5, level[0]=1 from the same cycle, other channels stay 0.
- Mode 00, w[1] toggles 1,0,1,0 for 3 cycles, then stays high → no pulse during the bounce. A single pulse occurs 4 stable samples after the last toggle reaches s.
- Mode 10: press and release w[2], each held 10 cycles → two pulses, on the rise and the fall. Mode 01 → only the fall pulse. Mode 11 → none, but level still follows.
- Assert reset while channel 3 is in RISE_WAIT with cnt=2 → outputs go to 0 immediately. After release, with w still high, a fresh full-latency rise pulse occurs.
- EDGE_STICKY_EN: pulse on w[0], then event_clr[0] 3 cycles later → event_flag[0] goes 1 to 0. With clear asserted in the same cycle as a new pulse → flag stays 1.
- Simultaneous rises on all channels → z=4'b1111 for one cycle and any_z=1 in the same cycle.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and constants for the debounced edge detector: channel FSM
// states, edge_mode encodings and the debounce counter width helper.
package edge_det_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } state_t;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Width that can hold 0..n inclusive, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounced_edge_detector_edge_channel.sv
// One channel: synchroniser, stable-count debounce FSM, registered event pulse
// and, when EDGE_STICKY_EN is defined, a sticky event flag.
module edge_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       w,
    input  logic [1:0] edge_mode,
    input  logic       event_clr,
    output logic       level,
    output logic       z,
    output logic       z_next,
    output logic       event_flag
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   z_q, z_d;
    logic                   s, rise, fall;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], w};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        fall    = 1'b0;
        case (state_q)
            LOW: if (s) begin
                if (DEBOUNCE_CYCLES == 1) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise    = 1'b1;
                end else begin
                    state_d = RISE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: if (!s) begin
                if (DEBOUNCE_CYCLES == 1) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall    = 1'b1;
                end else begin
                    state_d = FALL_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Mode is looked at on the same edge that accepts the new level.
    assign z_d = (rise && (edge_mode == MODE_RISE || edge_mode == MODE_BOTH)) ||
                 (fall && (edge_mode == MODE_FALL || edge_mode == MODE_BOTH));

    // NOTE: reset is asynchronous, so it sits in the sensitivity list and wins over the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign level  = (state_q == HIGH) || (state_q == FALL_WAIT);
    assign z      = z_q;
    assign z_next = z_d;

`ifdef EDGE_STICKY_EN
    logic flag_q, flag_d;

    // A new pulse takes priority over a simultaneous clear.
    always_comb begin
        flag_d = flag_q;
        if (z_d)            flag_d = 1'b1;
        else if (event_clr) flag_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) flag_q <= 1'b0;
        else       flag_q <= flag_d;
    end

    assign event_flag = flag_q;
`else
    logic unused_event_clr;
    assign unused_event_clr = event_clr;
    assign event_flag       = 1'b0;
`endif

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel debounced edge detector top: one edge_channel per input and a
// registered OR of all pulses. Define EDGE_STICKY_EN to enable sticky flags.
module debounced_edge_detector
    import edge_det_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] w,
    input  logic [1:0]          edge_mode,
    input  logic [CHANNELS-1:0] event_clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] z,
    output logic                any_z,
    output logic [CHANNELS-1:0] event_flag
);

    logic [CHANNELS-1:0] z_next;
    logic                any_z_q, any_z_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .w         (w[i]),
            .edge_mode (edge_mode),
            .event_clr (event_clr[i]),
            .level     (level[i]),
            .z         (z[i]),
            .z_next    (z_next[i]),
            .event_flag(event_flag[i])
        );
    end

    // Built from the channels' next-pulse terms so any_z lands in the same cycle as z.
    assign any_z_d = |z_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) any_z_q <= 1'b0;
        else       any_z_q <= any_z_d;
    end

    assign any_z = any_z_q;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Scoreboard bench: each stimulus pushes the pulse it should cause; a negedge
// monitor pops and compares when that edge arrives and flags stray pulses.
module tb_debounced_edge_detector;
    import edge_det_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] w = '0;
    logic [1:0] edge_mode = MODE_RISE;
    logic [3:0] event_clr = '0;
    logic [3:0] level, z, event_flag;
    logic       any_z;

    typedef struct {
        int         at;
        logic [3:0] z;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;

    debounced_edge_detector #(
        .CHANNELS       (4),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .w         (w),
        .edge_mode (edge_mode),
        .event_clr (event_clr),
        .level     (level),
        .z         (z),
        .any_z     (any_z),
        .event_flag(event_flag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Stimulus changes now are captured on the next edge; the pulse follows LAT edges later.
    task automatic expect_pulse(input logic [3:0] mask);
        exp_t e;
        e.at = edge_n + 1 + LAT;
        e.z  = mask;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at < edge_n) begin
            e = sb.pop_front();
            check("missed_pulse", {3'b0, any_z, z}, {3'b0, |e.z, e.z});
        end
        if (sb.size() > 0 && sb[0].at == edge_n) begin
            e = sb.pop_front();
            check("pulse", {3'b0, any_z, z}, {3'b0, |e.z, e.z});
        end else if (z != '0 || any_z) begin
            check("spurious_pulse", {3'b0, any_z, z}, 8'h00);
        end
    end

    task automatic press_release(input string tag, input logic [1:0] mode, input int ch,
                                 input bit exp_rise, input bit exp_fall);
        int n;
        edge_mode = mode;
        n = edge_n;
        w[ch] = 1'b1;
        if (exp_rise) expect_pulse(4'(1 << ch));
        if (exp_fall) begin
            exp_t e;
            e.at = n + 11 + LAT;
            e.z  = 4'(1 << ch);
            sb.push_back(e);
        end
        tick(7);
        check({tag, "_level_hi"}, {4'b0, level}, {4'b0, 4'(1 << ch)});
        tick(3);
        w[ch] = 1'b0;
        tick(12);
        check({tag, "_level_lo"}, {4'b0, level}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_level", {4'b0, level}, 8'h00);
        check("rst_z",     {3'b0, any_z, z}, 8'h00);
        check("rst_flag",  {4'b0, event_flag}, 8'h00);
        reset = 1'b0;
        tick(2);

        // Rising edge on channel 0 with full latency.
        edge_mode = MODE_RISE;
        w[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(LAT);
        check("s1_level_pre", {4'b0, level}, 8'h00);
        tick(1);
        check("s1_level", {4'b0, level}, 8'h01);
        tick(4);
        w[0] = 1'b0;
        tick(12);

        // Bounce on channel 1 before it settles high.
        w[1] = 1'b1; tick(1);
        w[1] = 1'b0; tick(1);
        w[1] = 1'b1; tick(1);
        w[1] = 1'b0; tick(1);
        w[1] = 1'b1;
        expect_pulse(4'b0010);
        tick(LAT);
        check("s2_level_pre", {4'b0, level}, 8'h00);
        tick(3);
        check("s2_level", {4'b0, level}, 8'h02);
        w[1] = 1'b0;
        tick(12);

        press_release("both", MODE_BOTH, 2, 1'b1, 1'b1);
        press_release("fall", MODE_FALL, 2, 1'b0, 1'b1);
        press_release("off",  MODE_OFF,  2, 1'b0, 1'b0);

        // Reset while channel 3 is mid-wait, with channel 1 already HIGH.
        edge_mode = MODE_OFF;
        w[1] = 1'b1;
        tick(8);
        check("pre_rst_level", {4'b0, level}, 8'h02);
        edge_mode = MODE_RISE;
        w[3] = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        check("mid_rst_level", {4'b0, level}, 8'h00);
        check("mid_rst_z",     {3'b0, any_z, z}, 8'h00);
        tick(2);
        reset = 1'b0;
        expect_pulse(4'b1010);
        tick(LAT + 2);
        check("post_rst_level", {4'b0, level}, 8'h0a);
        w = '0;
        tick(12);

`ifdef EDGE_STICKY_EN
        w[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(LAT + 1);
        check("flag_set", {4'b0, event_flag}, 8'h01);
        tick(3);
        check("flag_hold", {4'b0, event_flag}, 8'h01);
        event_clr[0] = 1'b1;
        tick(1);
        event_clr[0] = 1'b0;
        check("flag_clr", {4'b0, event_flag}, 8'h00);
        w[0] = 1'b0;
        tick(12);
        w[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(LAT);
        event_clr[0] = 1'b1;
        tick(1);
        event_clr[0] = 1'b0;
        check("flag_set_wins", {4'b0, event_flag}, 8'h01);
        w[0] = 1'b0;
        tick(12);
`else
        w[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(LAT);
        event_clr[0] = 1'b1;
        tick(1);
        event_clr[0] = 1'b0;
        check("flag_tied_low", {4'b0, event_flag}, 8'h00);
        w[0] = 1'b0;
        tick(12);
`endif

        // All channels rise together.
        w = 4'b1111;
        expect_pulse(4'b1111);
        tick(LAT + 2);
        check("all_level", {4'b0, level}, 8'h0f);
        w = '0;
        tick(12);

        tick(3);
        check("sb_empty", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
